dmem_sized: RTL
===============

Name: dmem_sized

Overview:
- Parametrised successor to the single-word data memory in the MIPS pipeline's MEM stage.
- Adds byte, halfword and word loads and stores with sign/zero extension, plus a configurable address window and depth.
- Adds a configurable access latency behind a valid/ready request and response handshake, so the pipeline can stall on memory.
- Single outstanding access; word storage is an internal array.

Parameters:
- DATA_W, 32: word width in bits; fixed at 32 for MIPS, four byte lanes.
- DEPTH, 64: number of words; power of two, at least 2.
- BASE_ADDR, 32'hFFFFFF00: byte address of word 0.
- LATENCY, 1: cycles from request accept to rsp_valid; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  access faulted; only driven with DMEM_ERR_EN, otherwise tied 0.

Behaviour:
- Reset values: FSM = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- Memory contents are zeroed at time zero only. Reset does not clear them.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, latch we, size, signed, addr and wdata.
  - IDLE exit: if LATENCY = 1, go to RESP; otherwise go to WAIT with counter = LATENCY-2.
  - WAIT: req_ready = 0. Decrement the counter; when it reaches 0, go to RESP.
  - Access point: on the edge that enters RESP, perform the store or sample the load.
  - RESP: rsp_valid = 1 and outputs are held stable until rsp_ready. Then go to IDLE.
- No request/response overlap: req_ready stays 0 in RESP, even when rsp_ready is high. Throughput is one access per LATENCY+1 cycles when rsp_ready is held at 1.
- Address mapping:
  - offset = req_addr - BASE_ADDR, modulo 2^32.
  - Word index = offset[log2(DEPTH)+1:2]. Upper offset bits are ignored, so accesses wrap modulo DEPTH words.
  - Lane = req_addr[1:0], little-endian: lane 0 = bits 7:0.
- Stores:
  - byte: writes wdata[7:0] into the lane.
  - half: writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - word: writes all lanes.
  - Lanes not written keep their value.
- Loads: extract the addressed byte or half, then extend per req_signed. Word loads ignore req_signed.
- Size 11 is treated as a word access.
- Misaligned half or word (without DMEM_ERR_EN): the low address bits are forced to 0 (half: bit 0; word: bits 1:0).
- Reset asserted mid-access: the FSM aborts to IDLE and no response is produced. A store that has not reached its access edge is not committed.
- Input changes while not in IDLE have no effect.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined: rsp_err = 1 in RESP when any of the following hold:
  - the access is misaligned (half with addr[0] = 1, or word with addr[1:0] ≠ 0);
  - req_size = 11;
  - offset ≥ DEPTH*4.
- On a faulting store the memory is unchanged. On a faulting load rsp_rdata = 0.
- Not defined: no fault checks; behaviour follows the forcing and wrap rules above; rsp_err is tied 0.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state typedef;
  - default BASE_ADDR constant.
- Sub-module dmem_lane_align, combinational:
  - store path: right-aligned wdata to a lane-shifted word plus a 4-bit byte-enable mask;
  - load path: raw word to extracted, extended data.
- Top level holds the FSM, counter, storage array and latches.

Test Plan:
1. LATENCY = 1: store word 32'hDEADBEEF to FFFFFF04, then load word → rsp_rdata = DEADBEEF. rsp_valid rises 1 cycle after accept.
2. Byte path: store byte 8'h80 to FFFFFF05, then load byte signed → FFFFFF80; load byte unsigned → 00000080. A word load of FFFFFF04 → DEAD80EF.
3. Half path: store half 16'h8001 to FFFFFF0A, then load half signed → FFFF8001. Lanes 0–1 of that word are unchanged.
4. LATENCY = 4 with rsp_ready held 0 for 3 cycles:
   - req_ready = 0 from accept until the response completes;
   - rsp_valid appears exactly 4 cycles after accept and stays stable while rsp_ready = 0;
   - req_ready = 1 one cycle after the rsp_ready handshake.
5. Reset mid-WAIT:
   - LATENCY = 4, store 32'h12345678 to FFFFFF10; deassert rst_n 2 cycles after accept.
   - Required: rsp_valid = 0, FSM in IDLE, and a subsequent load of FFFFFF10 returns the prior value.
6. DMEM_ERR_EN defined, word store to FFFFFF02 → rsp_err = 1 and memory unchanged. Without the macro: rsp_err = 0 and the store lands at FFFFFF00.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared size encodings, FSM state type and default base address.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'hFFFF_FF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational lane steering: store data/byte enables and load
//            extraction with sign/zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wword,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] rdata
);

  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Misaligned halves/words snap down to their natural boundary.
  always_comb begin
    w_lane = 2'b00;
    case (size)
      SZ_BYTE: w_lane = addr_lo;
      SZ_HALF: w_lane = {addr_lo[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
  end

  assign w_byte = rword[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    wword = wdata;
    be    = 4'hF;
    rdata = rword;
    case (size)
      SZ_BYTE: begin
        wword = {4{wdata[7:0]}};
        be    = 4'b0001 << w_lane;
        rdata = is_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      SZ_HALF: begin
        wword = {2{wdata[15:0]}};
        be    = w_lane[1] ? 4'b1100 : 4'b0011;
        rdata = is_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      default: begin
        wword = wdata;
        be    = 4'hF;
        rdata = rword;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_sized.sv
// ============================================================================
// Module   : dmem_sized
// Brief    : Sized data memory with configurable latency and valid/ready
//            handshake. Define DMEM_ERR_EN to enable fault reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_sized
  import dmem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
  parameter int          LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                 c_idx_w    = $clog2(DEPTH);
  localparam int                 c_cnt_w    = $clog2(LATENCY + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic               c_direct   = (LATENCY == 1);

  dmem_state_t         r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [31:0]         r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: '0};

  logic                w_idle;
  logic                w_we;
  logic [1:0]          w_size;
  logic                w_signed;
  logic [31:0]         w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [31:0]         w_offset;
  logic [c_idx_w-1:0]  w_idx;
  logic [DATA_W-1:0]   w_rword;
  logic [DATA_W-1:0]   w_wword;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_ldata;
  logic [DATA_W-1:0]   w_rsp_data;
  logic                w_fault;
  logic                w_access;

  // With LATENCY=1 the access edge is the accept edge, so take the live
  // request; otherwise use the latched copy.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_we     = w_idle ? req_we     : r_we;
  assign w_size   = w_idle ? req_size   : r_size;
  assign w_signed = w_idle ? req_signed : r_signed;
  assign w_addr   = w_idle ? req_addr   : r_addr;
  assign w_wdata  = w_idle ? req_wdata  : r_wdata;

  assign w_offset = w_addr - BASE_ADDR;
  assign w_idx    = w_offset[c_idx_w+1:2];
  assign w_rword  = r_mem[w_idx];

  assign w_access = rst_n && ((w_idle && req_valid && c_direct) ||
                              ((r_state == ST_WAIT) && (r_cnt == '0)));

`ifdef DMEM_ERR_EN
  localparam logic [32:0] c_span = 33'(DEPTH) * 33'd4;

  always_comb begin
    w_fault = 1'b0;
    case (w_size)
      SZ_BYTE: w_fault = 1'b0;
      SZ_HALF: w_fault = w_addr[0];
      SZ_WORD: w_fault = |w_addr[1:0];
      default: w_fault = 1'b1;
    endcase
    if ({1'b0, w_offset} >= c_span) w_fault = 1'b1;
  end
`else
  logic w_unused_offset;
  assign w_unused_offset = ^w_offset[31:c_idx_w+2];
  assign w_fault         = 1'b0;
`endif

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size      (w_size),
    .is_signed (w_signed),
    .addr_lo   (w_addr[1:0]),
    .wdata     (w_wdata),
    .rword     (w_rword),
    .wword     (w_wword),
    .be        (w_be),
    .rdata     (w_ldata)
  );

  assign w_rsp_data = (w_we || w_fault) ? '0 : w_ldata;

  // Storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_access && w_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (c_direct) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_err   <= w_fault;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_cnt_init;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= w_fault;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
